mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single-port instruction/data RAM between the instruction-fetch unit and the load/store path of the rv32i core. The load/store path is driven by the decoder's `mem_op` and `ram_mask` outputs. It grants at most one access per cycle and tracks the outstanding read. It returns read data to the requester that issued the read, with fixed latency. A starvation counter guarantees fetch progress under sustained load/store traffic.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width of both requesters
- `RAM_LATENCY`, 1, cycles from `ram_en` (read) to valid `ram_rdata`; legal range 1..4
- `LS_STREAK_MAX`, 4, consecutive load/store grants allowed while fetch waits; legal range 1..15

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_gnt`
- `if_addr`  in  ADDR_W  fetch byte address; bits [1:0] ignored
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  `if_rdata` valid
- `if_rdata`  out  32  instruction word
- `ls_req`  in  1  load/store request; held with all `ls_*` inputs stable until `ls_gnt`
- `ls_op`  in  1  `mem_op_e`: MEM_LOAD=0, MEM_STORE=1
- `ls_addr`  in  ADDR_W  data byte address; bits [1:0] ignored
- `ls_wdata`  in  32  store data, already lane-aligned
- `ls_be`  in  4  byte enables, already lane-aligned
- `ls_gnt`  out  1  load/store accepted this cycle
- `ls_rvalid`  out  1  `ls_rdata` valid (loads only)
- `ls_rdata`  out  32  raw RAM word; the core performs extension per `reg_mask`
- `ram_en`  out  1  RAM access strobe
- `ram_we`  out  1  write strobe; only high together with `ram_en`
- `ram_addr`  out  ADDR_W-2  word address = granted addr[ADDR_W-1:2]
- `ram_wdata`  out  32  write data
- `ram_be`  out  4  write byte enables; forced 4'b1111 on reads
- `ram_rdata`  in  32  RAM read data

## Operation
- All outputs are combinational from the current requests and the registered state; no request is registered before reaching the RAM.
- State: `rd_pending` (1b), `rd_owner` (0=fetch, 1=ls), `lat_cnt` (0..RAM_LATENCY), `streak` (0..LS_STREAK_MAX).
- `can_issue` = !rd_pending || (lat_cnt==1), i.e. a read returns this cycle.
- Arbitration, when `can_issue`:
  - Only `ls_req` asserted: grant ls.
  - Only `if_req` asserted: grant fetch.
  - Both asserted: grant ls if `streak` < LS_STREAK_MAX, otherwise grant fetch.
- Grant drives `ram_en`=1, plus `ram_we`=`ls_op` for ls and 0 for fetch. `ram_addr`, `ram_wdata` and `ram_be` are taken from the granted requester. When no grant is given, `ram_en`=0 and the other RAM outputs are 0.
- `streak` update:
  - ls granted while `if_req` asserted: increment, saturating.
  - Fetch granted: clear to 0.
  - `if_req` deasserted: clear to 0.
  - Otherwise: hold.
- Read grant (fetch, or ls with MEM_LOAD): set `rd_pending`, load `lat_cnt`=RAM_LATENCY, record `rd_owner`.
- While `rd_pending`, `lat_cnt` decrements each cycle.
- In the cycle `lat_cnt`==1, the arbiter pulses `if_rvalid` or `ls_rvalid` per `rd_owner`, and `if_rdata`/`ls_rdata` = `ram_rdata`. `rd_pending` clears unless a new read is granted in that same cycle.
- `if_rdata`/`ls_rdata` are 0 whenever the matching rvalid is low.
- Store grant: complete at grant. No rvalid is produced and no pending state is set.
- At most one read is outstanding at any time, and read returns are strictly in order.

## Timing
- Reset values: all outputs 0, `rd_pending`=0, `lat_cnt`=0, `streak`=0.
- Grant latency is 0 cycles: `*_gnt` is asserted in the same cycle as `*_req` when `can_issue` holds and arbitration selects that requester.
- Read data latency: rvalid asserts exactly RAM_LATENCY cycles after the grant cycle.
- Throughput:
  - RAM_LATENCY=1: back-to-back reads every cycle.
  - General case: one read per RAM_LATENCY cycles; stores may issue only when `can_issue`.
- Simultaneous return and new grant in the same cycle: the return goes to the old owner, and the new owner is recorded for the next read.
- `reset` asserted mid-read: the pending read is discarded, with no rvalid afterwards. The arbiter is idle the cycle after reset deasserts.
- A request deasserted before grant is a protocol violation. The arbiter tracks no state per request, so it behaves as if the request never existed.

## Test plan
- Reset, then `if_req`=1 with `if_addr`=0x100 and RAM_LATENCY=1 → `if_gnt`=1, `ram_addr`=0x40 in cycle 0; `if_rvalid`=1 with `ram_rdata` passed through in cycle 1.
- `if_req` and `ls_req` (load) asserted continuously with LS_STREAK_MAX=4 → grant pattern ls,ls,ls,ls,if repeating; `streak` never exceeds 4.
- Store: `ls_op`=1, `ls_addr`=0x203, `ls_be`=4'b1000, `ls_wdata`=0xAB000000 → `ram_we`=1, `ram_addr`=0x80, `ram_be`=4'b1000 in grant cycle; no `ls_rvalid` ever.
- RAM_LATENCY=3 with fetch read then ls load requested together → fetch grant at t0; no grant at t1 or t2; at t3 `if_rvalid`=1 and `ls_gnt`=1; at t6 `ls_rvalid`=1.
- Load granted, `reset` pulsed one cycle later → no `ls_rvalid` is produced; all outputs are 0 the cycle after reset.
- Idle with no requests for 10 cycles → `ram_en`=0 and both rvalids stay 0; `streak` stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the load/store path.
// Zero-cycle grant, one outstanding read with fixed-latency in-order return, fetch starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int RAM_LATENCY   = 1,
    parameter int LS_STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic              ls_op,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    input  logic [3:0]        ls_be,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [31:0]       ls_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    input  logic [31:0]       ram_rdata
);
    typedef enum logic { MEM_LOAD = 1'b0, MEM_STORE = 1'b1 } mem_op_e;
    typedef enum logic { OWNER_IF = 1'b0, OWNER_LS = 1'b1 } owner_e;

    logic       rd_pending, rd_pending_nxt;
    owner_e     rd_owner, rd_owner_nxt;
    logic [2:0] lat_cnt, lat_cnt_nxt;
    logic [3:0] streak, streak_nxt;
    logic       can_issue, rd_return, grant_if, grant_ls, new_read;
    logic       unused_addr_lsbs;

    assign unused_addr_lsbs = ^{if_addr[1:0], ls_addr[1:0]};

    // Handshake: a requester raises req and holds its inputs stable until gnt; the
    // transfer happens in the gnt cycle. rvalid is a one-cycle pulse without back-pressure.
    always_comb begin
        rd_return = !reset && rd_pending && (lat_cnt == 3'd1);
        can_issue = !reset && (!rd_pending || (lat_cnt == 3'd1));
        grant_ls  = can_issue && ls_req && (!if_req || (streak < 4'(LS_STREAK_MAX)));
        grant_if  = can_issue && if_req && !grant_ls;
        new_read  = grant_if || (grant_ls && (ls_op == MEM_LOAD));
    end

    always_comb begin
        if_gnt    = grant_if;
        ls_gnt    = grant_ls;
        ram_en    = grant_if || grant_ls;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_be    = '0;
        if (grant_ls) begin
            ram_we    = ls_op;
            ram_addr  = ls_addr[ADDR_W-1:2];
            ram_wdata = ls_wdata;
            ram_be    = (ls_op == MEM_STORE) ? ls_be : 4'b1111;
        end else if (grant_if) begin
            ram_addr  = if_addr[ADDR_W-1:2];
            ram_be    = 4'b1111;
        end
        if_rvalid = rd_return && (rd_owner == OWNER_IF);
        ls_rvalid = rd_return && (rd_owner == OWNER_LS);
        if_rdata  = if_rvalid ? ram_rdata : '0;
        ls_rdata  = ls_rvalid ? ram_rdata : '0;
    end

    // A read granted in the return cycle takes over the pending slot directly.
    always_comb begin
        rd_pending_nxt = rd_pending;
        rd_owner_nxt   = rd_owner;
        lat_cnt_nxt    = lat_cnt;
        streak_nxt     = streak;
        if (new_read) begin
            rd_pending_nxt = 1'b1;
            lat_cnt_nxt    = 3'(RAM_LATENCY);
            rd_owner_nxt   = grant_ls ? OWNER_LS : OWNER_IF;
        end else if (rd_pending) begin
            lat_cnt_nxt = lat_cnt - 3'd1;
            if (lat_cnt == 3'd1) begin
                rd_pending_nxt = 1'b0;
            end
        end
        if (!if_req || grant_if) begin
            streak_nxt = '0;
        end else if (grant_ls && (streak < 4'(LS_STREAK_MAX))) begin
            streak_nxt = streak + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pending <= 1'b0;
            rd_owner   <= OWNER_IF;
            lat_cnt    <= '0;
            streak     <= '0;
        end else begin
            rd_pending <= rd_pending_nxt;
            rd_owner   <= rd_owner_nxt;
            lat_cnt    <= lat_cnt_nxt;
            streak     <= streak_nxt;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance at RAM_LATENCY=1 with a read-return scoreboard,
// one at RAM_LATENCY=3 for multi-cycle latency, overlap and reset-discard sequences.
module tb_mem_port_arbiter;
    localparam int STREAK_MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int streak_m = 0;
    logic [32:0] exp_q[$];
    logic [32:0] sb_exp;
    logic [1:0]  gnt_seen;

    logic        reset, if_req, ls_req, ls_op;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [3:0]  ls_be;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, ram_en, ram_we;
    logic [31:0] if_rdata, ls_rdata, ram_wdata;
    logic [29:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata = 32'h0;

    logic        reset3, if_req3, ls_req3, ls_op3;
    logic [31:0] if_addr3, ls_addr3;
    logic        if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, ram_en3, ram_we3;
    logic [31:0] if_rdata3, ls_rdata3, ram_wdata3;
    logic [29:0] ram_addr3;
    logic [3:0]  ram_be3;
    logic [31:0] p3_a = 32'h0, p3_b = 32'h0, ram_rdata3 = 32'h0;

    mem_port_arbiter #(.ADDR_W(32), .RAM_LATENCY(1), .LS_STREAK_MAX(STREAK_MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_op(ls_op), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_be(ram_be), .ram_rdata(ram_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .RAM_LATENCY(3), .LS_STREAK_MAX(STREAK_MAX)) dut3 (
        .clk(clk), .reset(reset3),
        .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .ls_req(ls_req3), .ls_op(ls_op3), .ls_addr(ls_addr3), .ls_wdata(32'h0), .ls_be(4'h0),
        .ls_gnt(ls_gnt3), .ls_rvalid(ls_rvalid3), .ls_rdata(ls_rdata3),
        .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
        .ram_be(ram_be3), .ram_rdata(ram_rdata3)
    );

    function automatic logic [31:0] fdata(input logic [29:0] wa);
        return {wa[15:0], ~wa[15:0]} ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [159:0] outs1();
        return 160'({if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
                     ram_en, ram_we, ram_addr, ram_wdata, ram_be});
    endfunction

    function automatic logic [159:0] outs3();
        return 160'({if_gnt3, if_rvalid3, if_rdata3, ls_gnt3, ls_rvalid3, ls_rdata3,
                     ram_en3, ram_we3, ram_addr3, ram_wdata3, ram_be3});
    endfunction

    // RAM models: word contents are a fixed function of the word address.
    always @(posedge clk) begin
        ram_rdata  <= (ram_en && !ram_we) ? fdata(ram_addr) : 32'hDEAD_BEEF;
        p3_a       <= (ram_en3 && !ram_we3) ? fdata(ram_addr3) : 32'h0BAD_0BAD;
        p3_b       <= p3_a;
        ram_rdata3 <= p3_b;
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the latency-1 instance.
    always @(negedge clk) begin
        check("rdata_zero_when_no_rvalid", 160'({if_rvalid ? 32'h0 : if_rdata, ls_rvalid ? 32'h0 : ls_rdata}), '0);
        check("rvalid_exclusive", 160'(if_rvalid && ls_rvalid), '0);
        if (if_rvalid || ls_rvalid) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL sb_unexpected_rvalid observed=rvalid expected=no_outstanding_read");
            end
            if (exp_q.size() != 0) begin
                sb_exp = exp_q.pop_front();
                check("sb_read_return", 160'({ls_rvalid, ls_rvalid ? ls_rdata : if_rdata}), 160'(sb_exp));
            end
        end
    end

    task automatic lat1_step(input int p_if, input int p_ls, input int p_store, output logic [1:0] gnt_out);
        logic e_if, e_ls;
        if (!if_req && ($urandom_range(0, 99) < 32'(p_if))) begin
            if_req  = 1'b1;
            if_addr = $urandom;
        end
        if (!ls_req && ($urandom_range(0, 99) < 32'(p_ls))) begin
            ls_req   = 1'b1;
            ls_op    = ($urandom_range(0, 99) < 32'(p_store));
            ls_addr  = $urandom;
            ls_wdata = $urandom;
            ls_be    = 4'($urandom);
        end
        @(negedge clk);
        e_ls = ls_req && (!if_req || (streak_m < STREAK_MAX));
        e_if = if_req && !e_ls;
        gnt_out = {if_gnt, ls_gnt};
        check("arb_grant", 160'({if_gnt, ls_gnt}), 160'({e_if, e_ls}));
        if (e_ls) begin
            check("ls_ram_ctl", 160'({ram_en, ram_we, ram_addr, ram_be}),
                  160'({1'b1, ls_op, ls_addr[31:2], ls_op ? ls_be : 4'hF}));
            check("ls_ram_wdata", 160'(ram_wdata), 160'(ls_wdata));
            if (!ls_op) exp_q.push_back({1'b1, fdata(ls_addr[31:2])});
        end else if (e_if) begin
            check("if_ram_ctl", 160'({ram_en, ram_we, ram_addr, ram_be, ram_wdata}),
                  160'({1'b1, 1'b0, if_addr[31:2], 4'hF, 32'h0}));
            exp_q.push_back({1'b0, fdata(if_addr[31:2])});
        end else begin
            check("no_grant_ram", 160'({ram_en, ram_we, ram_addr, ram_be, ram_wdata}), '0);
        end
        if (!if_req || e_if) streak_m = 0;
        else if (e_ls && (streak_m < STREAK_MAX)) streak_m++;
        @(posedge clk); #1;
        if (e_if) if_req = 1'b0;
        if (e_ls) ls_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_op = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
        reset3 = 1'b1; if_req3 = 1'b0; ls_req3 = 1'b0; ls_op3 = 1'b0;
        if_addr3 = '0; ls_addr3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("outputs_in_reset", outs1(), '0);
        @(posedge clk); #1;
        reset = 1'b0; reset3 = 1'b0;
        @(negedge clk);
        check("idle_after_reset", outs1(), '0);
        check("idle_after_reset_l3", outs3(), '0);

        // Single fetch at latency 1.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        check("fetch_gnt", 160'({if_gnt, ls_gnt, ram_en, ram_we}), 160'(4'b1010));
        check("fetch_ram_addr", 160'(ram_addr), 160'(30'h40));
        check("fetch_ram_be_wdata", 160'({ram_be, ram_wdata}), 160'({4'hF, 32'h0}));
        exp_q.push_back({1'b0, fdata(30'h40)});
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        check("fetch_rvalid_lat1", 160'({if_rvalid, ls_rvalid, if_rdata}), 160'({1'b1, 1'b0, fdata(30'h40)}));
        check("fetch_no_regrant", 160'(ram_en), '0);

        // Store, then ten idle cycles.
        @(posedge clk); #1;
        ls_req = 1'b1; ls_op = 1'b1; ls_addr = 32'h203; ls_be = 4'b1000; ls_wdata = 32'hAB00_0000;
        @(negedge clk);
        check("store_ctl", 160'({ls_gnt, if_gnt, ram_en, ram_we, ram_addr, ram_be}),
              160'({1'b1, 1'b0, 1'b1, 1'b1, 30'h80, 4'b1000}));
        check("store_wdata", 160'(ram_wdata), 160'(32'hAB00_0000));
        @(posedge clk); #1;
        ls_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_quiet", 160'({ram_en, if_rvalid, ls_rvalid, if_gnt, ls_gnt}), '0);
            @(posedge clk); #1;
        end

        // Sustained contention: ls,ls,ls,ls,if repeating.
        streak_m = 0;
        for (int i = 0; i < 15; i++) begin
            lat1_step(100, 100, 0, gnt_seen);
            check("streak_pattern", 160'(gnt_seen), 160'(((i % 5) == 4) ? 2'b10 : 2'b01));
        end

        // Random mixed traffic, then drain.
        for (int i = 0; i < 60; i++) lat1_step(50, 50, 30, gnt_seen);
        for (int i = 0; i < 4; i++) lat1_step(0, 0, 0, gnt_seen);

        // Latency 3: fetch read, then a load waits for the return cycle.
        if_req3 = 1'b1; if_addr3 = 32'h40;
        @(negedge clk);
        check("l3_t0_fetch_gnt", 160'({if_gnt3, ls_gnt3, ram_en3, ram_addr3}), 160'({1'b1, 1'b0, 1'b1, 30'h10}));
        @(posedge clk); #1;
        if_req3 = 1'b0; ls_req3 = 1'b1; ls_op3 = 1'b0; ls_addr3 = 32'h88;
        for (int t = 1; t <= 2; t++) begin
            @(negedge clk);
            check("l3_blocked", 160'({if_gnt3, ls_gnt3, ram_en3, if_rvalid3, ls_rvalid3}), '0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("l3_t3_return", 160'({if_rvalid3, if_rdata3, ls_rvalid3}), 160'({1'b1, fdata(30'h10), 1'b0}));
        check("l3_t3_ls_gnt", 160'({ls_gnt3, ram_en3, ram_we3, ram_addr3, ram_be3}),
              160'({1'b1, 1'b1, 1'b0, 30'h22, 4'hF}));
        @(posedge clk); #1;
        ls_req3 = 1'b0;
        for (int t = 4; t <= 5; t++) begin
            @(negedge clk);
            check("l3_wait_ls", 160'({if_rvalid3, ls_rvalid3, ram_en3}), '0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("l3_t6_ls_return", 160'({ls_rvalid3, ls_rdata3, if_rvalid3}), 160'({1'b1, fdata(30'h22), 1'b0}));
        @(posedge clk); #1;

        // Latency 3: reset one cycle after a load grant discards the read.
        ls_req3 = 1'b1; ls_op3 = 1'b0; ls_addr3 = 32'h300;
        @(negedge clk);
        check("l3_rst_load_gnt", 160'({ls_gnt3, ram_en3, ram_addr3}), 160'({1'b1, 1'b1, 30'hC0}));
        @(posedge clk); #1;
        ls_req3 = 1'b0; reset3 = 1'b1;
        @(negedge clk);
        check("l3_in_reset", outs3(), '0);
        @(posedge clk); #1;
        reset3 = 1'b0;
        @(negedge clk);
        check("l3_after_reset", outs3(), '0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("l3_no_stale_rvalid", 160'({ls_rvalid3, if_rvalid3, ls_rdata3, if_rdata3}), '0);
        end

        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
